// File: rtl/keypad_debounce_10.sv
// Debounced, synchronised front end for the 10-key decimal keypad.
// Emits a held one-hot code + enable for the BCD encoder, plus press and multi-key strobes.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | all keys up, waiting for any nonzero synchronised pattern
// DEB_PRESS | candidate pattern captured, counting consecutive stable cycles
// HELD      | press accepted (or multi-key rejected), waiting for a change
// DEB_REL   | pattern changed, counting consecutive all-up cycles
module keypad_debounce_10 #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] key_in,
   output logic [9:0] key_onehot,
   output logic       key_en,
   output logic       key_pulse,
   output logic       multi_err
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DEB_PRESS = 2'd1,
      HELD      = 2'd2,
      DEB_REL   = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   state_t           state, state_nx;
   logic [9:0]       sync_meta, sync;
   logic [9:0]       cand, cand_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [9:0]       onehot_nx;
   logic             en_nx, pulse_nx, err_nx;
   logic             cand_single;

   // A power-of-two test: exactly one bit set.
   assign cand_single = (cand != 10'd0) && ((cand & (cand - 10'd1)) == 10'd0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_meta  <= '0;
         sync       <= '0;
         state      <= IDLE;
         cand       <= '0;
         cnt        <= '0;
         key_onehot <= '0;
         key_en     <= 1'b0;
         key_pulse  <= 1'b0;
         multi_err  <= 1'b0;
      end else begin
         sync_meta  <= key_in;
         sync       <= sync_meta;
         state      <= state_nx;
         cand       <= cand_nx;
         cnt        <= cnt_nx;
         key_onehot <= onehot_nx;
         key_en     <= en_nx;
         key_pulse  <= pulse_nx;
         multi_err  <= err_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      cand_nx   = cand;
      cnt_nx    = cnt;
      onehot_nx = key_onehot;
      en_nx     = key_en;
      pulse_nx  = 1'b0;
      err_nx    = 1'b0;

      case (state)
         IDLE: begin
            if (sync != 10'd0) begin
               cand_nx  = sync;
               cnt_nx   = '0;
               state_nx = DEB_PRESS;
            end
         end
         DEB_PRESS: begin
            if (sync != cand) begin
               cnt_nx   = '0;
               state_nx = IDLE;
            end else if (cnt < CNT_MAX) begin
               cnt_nx = cnt + CNT_W'(1);
            end else begin
               state_nx = HELD;
               if (cand_single) begin
                  onehot_nx = cand;
                  en_nx     = 1'b1;
                  pulse_nx  = 1'b1;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         HELD: begin
            if (sync != cand) begin
               cnt_nx   = '0;
               state_nx = DEB_REL;
            end
         end
         DEB_REL: begin
            if (sync == cand) begin
               state_nx = HELD;
            end else if (sync == 10'd0) begin
               if (cnt < CNT_MAX) begin
                  cnt_nx = cnt + CNT_W'(1);
               end else begin
                  onehot_nx = '0;
                  en_nx     = 1'b0;
                  state_nx  = IDLE;
               end
            end else begin
               // Another key still down: release only counts once every key is up.
               cnt_nx = '0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_keypad_debounce_10.sv
// Table-driven bench for keypad_debounce_10 with DEBOUNCE_CYCLES = 4.
// Each row gives the inputs for one clock edge and the outputs expected just after it.
module tb_keypad_debounce_10;

   logic       clk;
   logic       rst_n;
   logic [9:0] key_in;
   logic [9:0] key_onehot;
   logic       key_en;
   logic       key_pulse;
   logic       multi_err;

   int tests;
   int fails;

   keypad_debounce_10 #(.DEBOUNCE_CYCLES(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_onehot(key_onehot),
      .key_en    (key_en),
      .key_pulse (key_pulse),
      .multi_err (multi_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [9:0] key;
      logic       rstn;
      logic [9:0] onehot;
      logic       en;
      logic       pulse;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic [9:0] k, input logic r, input int n,
                      input logic [9:0] oh, input logic en, input logic p, input logic e);
      vec_t v;
      for (int i = 0; i < n; i++) begin
         v.key    = k;
         v.rstn   = r;
         v.onehot = oh;
         v.en     = en;
         v.pulse  = p;
         v.err    = e;
         vecs.push_back(v);
      end
   endtask

   task automatic tick(input logic [9:0] k);
      key_in = k;
      @(posedge clk);
      #1;
   endtask

   task automatic check_invariants(input int idx);
      logic ok;
      ok = !(key_pulse && multi_err)
           && ((key_onehot & (key_onehot - 10'd1)) == 10'd0)
           && (key_en == (key_onehot != 10'd0));
      tests++;
      if (!ok) begin
         fails++;
         $display("FAIL invariant row %0d: onehot=%b en=%b pulse=%b err=%b", idx,
                  key_onehot, key_en, key_pulse, multi_err);
      end
   endtask

   initial begin
      int   rise;
      bit   found;
      bit   bad;
      tests  = 0;
      fails  = 0;
      rst_n  = 1'b0;
      key_in = '0;

      // reset
      add(10'h000, 1'b0, 2, 10'h000, 0, 0, 0);
      add(10'h000, 1'b1, 3, 10'h000, 0, 0, 0);
      // clean press of digit 3, held 20 cycles
      add(10'h008, 1'b1, 6,  10'h000, 0, 0, 0);
      add(10'h008, 1'b1, 1,  10'h008, 1, 1, 0);
      add(10'h008, 1'b1, 13, 10'h008, 1, 0, 0);
      add(10'h000, 1'b1, 6,  10'h008, 1, 0, 0);
      add(10'h000, 1'b1, 4,  10'h000, 0, 0, 0);
      // bouncy press of digit 5
      add(10'h000, 1'b1, 2, 10'h000, 0, 0, 0);
      add(10'h020, 1'b1, 2, 10'h000, 0, 0, 0);
      add(10'h000, 1'b1, 2, 10'h000, 0, 0, 0);
      add(10'h020, 1'b1, 2, 10'h000, 0, 0, 0);
      add(10'h000, 1'b1, 2, 10'h000, 0, 0, 0);
      add(10'h020, 1'b1, 6, 10'h000, 0, 0, 0);
      add(10'h020, 1'b1, 1, 10'h020, 1, 1, 0);
      add(10'h020, 1'b1, 5, 10'h020, 1, 0, 0);
      add(10'h000, 1'b1, 6, 10'h020, 1, 0, 0);
      add(10'h000, 1'b1, 4, 10'h000, 0, 0, 0);
      // multi-key 0 and 1
      add(10'h003, 1'b1, 6,  10'h000, 0, 0, 0);
      add(10'h003, 1'b1, 1,  10'h000, 0, 0, 1);
      add(10'h003, 1'b1, 13, 10'h000, 0, 0, 0);
      add(10'h000, 1'b1, 10, 10'h000, 0, 0, 0);
      // release bounce on digit 9
      add(10'h200, 1'b1, 6, 10'h000, 0, 0, 0);
      add(10'h200, 1'b1, 1, 10'h200, 1, 1, 0);
      add(10'h200, 1'b1, 5, 10'h200, 1, 0, 0);
      add(10'h000, 1'b1, 2, 10'h200, 1, 0, 0);
      add(10'h200, 1'b1, 5, 10'h200, 1, 0, 0);
      add(10'h000, 1'b1, 6, 10'h200, 1, 0, 0);
      add(10'h000, 1'b1, 4, 10'h000, 0, 0, 0);
      // rollover 2 -> 2+7 -> 7 -> none; count restarts while 7 is still down
      add(10'h004, 1'b1, 6,  10'h000, 0, 0, 0);
      add(10'h004, 1'b1, 1,  10'h004, 1, 1, 0);
      add(10'h004, 1'b1, 5,  10'h004, 1, 0, 0);
      add(10'h084, 1'b1, 10, 10'h004, 1, 0, 0);
      add(10'h080, 1'b1, 10, 10'h004, 1, 0, 0);
      add(10'h000, 1'b1, 5,  10'h004, 1, 0, 0);
      add(10'h000, 1'b1, 5,  10'h000, 0, 0, 0);
      // reset mid-hold of digit 4
      add(10'h010, 1'b1, 6, 10'h000, 0, 0, 0);
      add(10'h010, 1'b1, 1, 10'h010, 1, 1, 0);
      add(10'h010, 1'b1, 5, 10'h010, 1, 0, 0);
      add(10'h010, 1'b0, 1, 10'h000, 0, 0, 0);
      add(10'h010, 1'b1, 6, 10'h000, 0, 0, 0);
      add(10'h010, 1'b1, 1, 10'h010, 1, 1, 0);
      add(10'h010, 1'b1, 3, 10'h010, 1, 0, 0);
      add(10'h000, 1'b1, 6, 10'h010, 1, 0, 0);
      add(10'h000, 1'b1, 4, 10'h000, 0, 0, 0);

      foreach (vecs[i]) begin
         key_in = vecs[i].key;
         rst_n  = vecs[i].rstn;
         @(posedge clk);
         #1;
         tests++;
         if ({key_onehot, key_en, key_pulse, multi_err} !==
             {vecs[i].onehot, vecs[i].en, vecs[i].pulse, vecs[i].err}) begin
            fails++;
            $display("FAIL row %0d: got onehot=%b en=%b pulse=%b err=%b, want onehot=%b en=%b pulse=%b err=%b",
                     i, key_onehot, key_en, key_pulse, multi_err,
                     vecs[i].onehot, vecs[i].en, vecs[i].pulse, vecs[i].err);
         end
         check_invariants(i);
      end

      // Digit 0 press: key_en must rise on the 7th edge together with key_pulse.
      rst_n = 1'b1;
      found = 0;
      rise  = 0;
      for (int c = 1; c <= 30 && !found; c++) begin
         tick(10'h001);
         if (key_en) begin
            found = 1;
            rise  = c;
         end
      end
      tests++;
      if (!found || rise != 7 || !key_pulse || key_onehot != 10'h001) begin
         fails++;
         $display("FAIL press_latency: found=%0d edge=%0d pulse=%b onehot=%b, want edge 7 pulse 1 onehot 0000000001",
                  found, rise, key_pulse, key_onehot);
      end

      // One-cycle glitches during HELD: all-up, then a different key.
      tick(10'h001);
      tick(10'h000);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick(10'h001);
         if (!key_en || key_onehot != 10'h001 || key_pulse || multi_err) bad = 1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL glitch_zero: outputs changed after 1-cycle dip, en=%b onehot=%b, want en 1 onehot 0000000001 no strobes",
                  key_en, key_onehot);
      end
      tick(10'h002);
      bad = 0;
      for (int c = 0; c < 10; c++) begin
         tick(10'h001);
         if (!key_en || key_onehot != 10'h001 || key_pulse || multi_err) bad = 1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL glitch_other: outputs changed after 1-cycle other key, en=%b onehot=%b, want en 1 onehot 0000000001 no strobes",
                  key_en, key_onehot);
      end

      // Release from HELD: key_en must fall on the 7th edge.
      found = 0;
      rise  = 0;
      for (int c = 1; c <= 30 && !found; c++) begin
         tick(10'h000);
         if (!key_en) begin
            found = 1;
            rise  = c;
         end
      end
      tests++;
      if (!found || rise != 7 || key_onehot != 10'h000) begin
         fails++;
         $display("FAIL release_latency: found=%0d edge=%0d onehot=%b, want edge 7 onehot 0",
                  found, rise, key_onehot);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/keypad_debounce_10.md
# keypad_debounce_10

Debounced, synchronised front end for the 10-key decimal keypad. It samples raw active-high key lines, filters contact bounce, and rejects multi-key presses. It presents a held one-hot key code plus enable, which connect directly to `cin`/`en` of the downstream BCD encoder. It also emits a single-cycle strobe per accepted press, so later digit-entry logic can capture each BCD value exactly once.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000 (20 ms at 50 MHz), is the number of consecutive stable cycles required to accept a press or release. Legal range is 2 or more; benches use 4.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES)`, is the debounce counter width.
- `clk`, input, 1 bit: the single clock for all logic.
- `rst_n`, input, 1 bit: synchronous active-low reset.
- `key_in`, input, 10 bits: raw asynchronous key lines, active high, with bit i corresponding to digit i.
- `key_onehot`, output, 10 bits: the accepted key, one-hot, held while the key is pressed; all zeros otherwise. Connects to the encoder's `cin`.
- `key_en`, output, 1 bit: high while a valid single key is held. Connects to the encoder's `en`.
- `key_pulse`, output, 1 bit: one-cycle strobe in the first cycle `key_en` is high for each accepted press.
- `multi_err`, output, 1 bit: one-cycle strobe when a stable multi-key press is rejected.

## Operation
- **Synchroniser:** two-flop synchroniser on all 10 bits, producing `sync[9:0]`. All decisions use `sync`.
- **Internal registers:**
  - `cand[9:0]`: candidate pattern.
  - `cnt[CNT_W-1:0]`: debounce counter.
  - `state`: one of IDLE, DEB_PRESS, HELD, DEB_REL.
- **IDLE**
  - If `sync` is 0, stay.
  - Otherwise set `cand` to `sync`, clear `cnt`, and go to DEB_PRESS.
- **DEB_PRESS**
  - If `sync` differs from `cand`, return to IDLE with `cnt` cleared. No outputs change.
  - Else, if `cnt` is less than DEBOUNCE_CYCLES-1, increment `cnt`.
  - Else (`cnt` equals DEBOUNCE_CYCLES-1), go to HELD and check `cand`:
    - If exactly one bit is set: `key_onehot` = `cand`, `key_en` = 1, `key_pulse` = 1.
    - Otherwise: `multi_err` = 1, and `key_en`/`key_onehot` stay 0 (rejected hold).
- **HELD**
  - If `sync` equals `cand`, stay.
  - Otherwise clear `cnt` and go to DEB_REL. Outputs are unchanged.
- **DEB_REL**
  - If `sync` equals `cand` (bounce back), return to HELD.
  - Else, if `sync` is 0:
    - While `cnt` is less than DEBOUNCE_CYCLES-1, increment `cnt`.
    - When `cnt` equals DEBOUNCE_CYCLES-1, clear `key_en` and `key_onehot` and go to IDLE.
  - Else (`sync` is some other nonzero pattern), clear `cnt` and stay. Release requires all keys up.
- **Single acceptance per press:** a new press is accepted only after a full release back to IDLE. Sliding from one key to another never produces a second `key_pulse` without all keys being released first.
- **Strobes:** `key_pulse` and `multi_err` are registered one-cycle strobes and are 0 in all other cycles. They are never both high.
- **Encoder contract:** `key_onehot` is either all zeros or one-hot, never multi-hot. `key_en` = 1 implies `key_onehot` is one-hot.

## Timing
- **Reset:** on a rising `clk` edge with `rst_n` = 0:
  - `key_onehot` = 0, `key_en` = 0, `key_pulse` = 0, `multi_err` = 0.
  - Synchroniser flops = 0, `cand` = 0, `cnt` = 0, `state` = IDLE.
  - Reset mid-debounce or mid-hold aborts with no strobe.
  - After reset is released, a key still held is treated as a new press and re-debounced.
- **Press latency:** let edge 1 be the first edge sampling the new stable `key_in`. Then:
  - edges 1–2: synchroniser;
  - edge 3: enter DEB_PRESS;
  - edge N+3: `key_en`/`key_onehot` rise and `key_pulse` is high for the following cycle (N = DEBOUNCE_CYCLES).
- **Release latency:** `key_en` falls at edge N+3 after `key_in` goes all-zero and stays all-zero, counted the same way.
- **Bounce filtering:** any mismatch shorter than N stable cycles restarts the count. A glitch of one cycle or less during HELD returns to HELD with no output change.
- **Counter saturation:** `cnt` never exceeds DEBOUNCE_CYCLES-1 and does not wrap.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4.
- **Clean press:** `key_in` = 10'b0000001000 held 20 cycles, then 0. Required: `key_onehot` = 10'b0000001000 and `key_en` = 1 from edge 7; `key_pulse` high exactly 1 cycle; `key_en` falls at edge 7 after release.
- **Bouncy press:** `key_in` toggles 0/bit 5 every 2 cycles for 10 cycles, then holds bit 5. Required: no `key_pulse` during bouncing; a single `key_pulse` with `key_onehot` = 10'b0000100000 7 edges after the hold begins.
- **Multi-key:** `key_in` = 10'b0000000011 held 20 cycles. Required: `multi_err` pulses once at edge 7; `key_en` stays 0 and `key_onehot` stays 0 throughout; release returns to IDLE.
- **Release bounce:** digit 9 held, then 2 zero cycles, then 9 again for 5 cycles, then 0. Required: `key_en` stays 1 through the 2-cycle dip; one `key_pulse` total; `key_en` falls 7 edges after the final release.
- **Rollover:** hold digit 2, press digit 7 before releasing 2, release 2 while holding 7, then release all. Required: only the digit-2 `key_pulse`; `key_onehot` stays 10'b0000000100 until the all-up release completes.
- **Reset mid-hold:** assert `rst_n` = 0 for 1 cycle while digit 4 is held. Required: all outputs 0 the cycle after the reset edge; `key_pulse` with digit 4 re-issued 7 edges after `rst_n` returns to 1.
